icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the datapath's instruction fetch port (imemREN/imemaddr in, ihit/imemload out) and the memory controller's instruction port.
- Hits return the stored word in the same cycle.
- Misses stall the datapath with ihit=0 while one word is fetched from memory and installed, after which the access hits.

Parameters:
- SETS, 16: number of one-word frames; power of two, ≥ 2.
- IDX_W, $clog2(SETS): index width, derived, not overridden.
- TAG_W, 30-IDX_W: tag width (address bits [31:2+IDX_W]).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  synchronous active-low reset, sampled on rising edge of CLK.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  32  instruction word; valid when ihit=1, else 0.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address, bits [1:0]=00.
- iwait  in  1  memory busy; iload is valid in a cycle where iREN=1 and iwait=0.
- iload  in  32  memory read data.

Behaviour:
- Address split: index = imemaddr[2+IDX_W-1:2], tag = imemaddr[31:2+IDX_W].
- Per-frame storage: valid bit, TAG_W tag, 32-bit data.
- Reset (nRST=0 at a rising edge):
  - All valid bits cleared; state <= IDLE; miss_addr <= 0.
  - Tag and data arrays need no reset.
  - From the first cycle after reset: ihit=0, imemload=0, iREN=0, iaddr=0 until a request arrives.
- FSM, two states:
  - IDLE:
    - hit = imemREN & valid[idx] & (tag[idx]==tag).
    - ihit=hit; imemload = hit ? data[idx] : 0; iREN=0; iaddr=0.
    - If imemREN & !hit: miss_addr <= {imemaddr[31:2],2'b00}; go to FETCH.
    - If imemREN=0: stay IDLE, no activity.
  - FETCH:
    - ihit=0, imemload=0, iREN=1, iaddr=miss_addr.
    - While iwait=1: hold.
    - When iwait=0: write data[miss idx]<=iload, tag<=miss tag, valid<=1; go to IDLE.
- Latency:
  - Hit: 0 cycles, combinational.
  - Miss: ihit asserts 1 cycle after the cycle with iwait=0. Total = 1 (detect) + N wait cycles + 1 (fill) + 0 (hit in IDLE).
- imemaddr changing during FETCH:
  - The fill completes to the latched miss_addr.
  - Return to IDLE re-evaluates the new address (may miss again).
- imemREN dropping during FETCH: the fill still completes; the memory handshake is never abandoned.
- Conflict miss: a new tag on a valid index overwrites that frame; no write-back (read-only).
- Reset in FETCH: state IDLE and iREN=0 from the next cycle; the in-flight memory response is discarded.
- No self-modifying-code coherence: data stores never update this cache.

Optional Feature:
- Macro ICACHE_STATS_EN. When defined, adds two outputs:
  - hit_cnt, 32-bit: +1 every cycle with ihit=1.
  - miss_cnt, 32-bit: +1 on each IDLE->FETCH transition.
  - Both are cleared by reset and wrap modulo 2^32.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset then imemREN=1, imemaddr=0x00000000, memory iwait=1 for 2 cycles, iload=0x8C010004 → iREN=1, iaddr=0 for 3 cycles; ihit=1 with imemload=0x8C010004 on the following cycle.
- Re-fetch 0x00000000 → ihit=1 in the same cycle, iREN stays 0.
- Fetch 0x00000040 (SETS=16: same index 0, different tag), iload=0x24020001 → miss, refill; then fetch 0x00000000 → miss again (evicted).
- Miss on 0x00000008; during FETCH change imemaddr to 0x0000000C and drop imemREN → iaddr stays 0x00000008 until iwait=0; frame 2 valid; IDLE then re-evaluates.
- Assert nRST=0 mid-FETCH → next cycle iREN=0, ihit=0; previously filled 0x00000000 now misses.
- With ICACHE_STATS_EN: sequence miss, hit, hit, miss → miss_cnt=2, hit_cnt counts every ihit=1 cycle (≥ 4 including post-fill hits).

Source files
------------

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm
// Purpose  : Direct-mapped read-only instruction cache with one-word frames.
//            Optional macro ICACHE_STATS_EN adds hit_cnt/miss_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module icache_dm #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [SETS-1:0]  r_valid;
   logic [TAG_W-1:0] r_tag  [SETS];
   logic [31:0]      r_data [SETS];
   logic [31:0]      r_miss_addr;

   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_miss_idx;
   logic [TAG_W-1:0] w_tag;
   logic [TAG_W-1:0] w_miss_tag;
   logic             w_hit;
   logic             w_fill;
   logic             w_miss_start;
   logic             w_unused;

   assign w_idx      = imemaddr[2 +: IDX_W];
   assign w_tag      = imemaddr[31 -: TAG_W];
   assign w_miss_idx = r_miss_addr[2 +: IDX_W];
   assign w_miss_tag = r_miss_addr[31 -: TAG_W];
   assign w_hit      = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   assign w_unused   = ^imemaddr[1:0];

   always_comb begin
      w_next_state = r_state;
      ihit         = 1'b0;
      imemload     = 32'd0;
      iREN         = 1'b0;
      iaddr        = 32'd0;
      w_fill       = 1'b0;
      w_miss_start = 1'b0;
      case (r_state)
         IDLE: begin
            ihit     = w_hit;
            imemload = w_hit ? r_data[w_idx] : 32'd0;
            if (imemREN && !w_hit) begin
               w_miss_start = 1'b1;
               w_next_state = FETCH;
            end
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = r_miss_addr;
            // The memory handshake always completes, whatever the datapath does meanwhile.
            if (!iwait) begin
               w_fill       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state     <= IDLE;
         r_valid     <= '0;
         r_miss_addr <= 32'd0;
      end else begin
         r_state <= w_next_state;
         if (w_miss_start)
            r_miss_addr <= {imemaddr[31:2], 2'b00};
         if (w_fill)
            r_valid[w_miss_idx] <= 1'b1;
      end
   end

   // Tag and data need no reset: a frame is only read once its valid bit is set.
   always_ff @(posedge CLK) begin
      if (nRST && w_fill) begin
         r_tag[w_miss_idx]  <= w_miss_tag;
         r_data[w_miss_idx] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         hit_cnt  <= 32'd0;
         miss_cnt <= 32'd0;
      end else begin
         if (ihit)
            hit_cnt <= hit_cnt + 32'd1;
         if (w_miss_start)
            miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_dm
// Purpose  : Randomized scoreboard bench for icache_dm against a frame-table
//            model; checks counters too when ICACHE_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_dm;
   localparam int SETS  = 16;
   localparam int IDX_W = $clog2(SETS);

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   icache_dm #(.SETS(SETS)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
      int          t_issue;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0, n_err = 0;
   int          n_push = 0, n_pop = 0;
   int          cyc = 0;
   int          wait_left = 0;
   logic [31:0] exp_iaddr = 32'd0;
   int          exp_hits = 0, exp_misses = 0;

   // Reference model: which word address each frame currently holds.
   bit          mv [SETS];
   logic [31:0] mwa[SETS];

   function automatic logic [31:0] mem_word(input logic [31:0] wa);
      case (wa)
         32'h0000_0000: mem_word = 32'h8C01_0004;
         32'h0000_0040: mem_word = 32'h2402_0001;
         default:       mem_word = (wa * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
      endcase
   endfunction

   function automatic int set_of(input logic [31:0] a);
      set_of = int'((a >> 2) % SETS);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
   endtask

   always @(posedge CLK) cyc++;

   // Memory responder: stalls for the programmed number of cycles, then returns data.
   initial begin
      iwait = 1'b1;
      iload = 32'd0;
      forever begin
         @(posedge CLK);
         #2;
         if (iREN) begin
            check("iaddr", iaddr, exp_iaddr);
            if (wait_left > 0) begin
               iwait = 1'b1;
               wait_left--;
            end else begin
               iwait = 1'b0;
            end
            iload = mem_word(iaddr);
         end else begin
            iwait = 1'($urandom_range(0, 1));
            iload = $urandom;
         end
      end
   end

   // Monitor: pops the scoreboard on every ihit and checks idle output values.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (nRST) begin
            if (ihit) begin
               if (!imemREN) begin
                  n_vec++; n_err++;
                  $display("FAIL hit_without_req: ihit=1 with imemREN=0 (cycle %0d)", cyc);
               end else if (sb.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_hit: addr %h data %h, none expected", imemaddr, imemload);
               end else begin
                  e = sb.pop_front();
                  n_pop++;
                  check("imemload", imemload, e.data);
                  check("latency", 32'(cyc - e.t_issue), 32'(e.lat));
               end
            end else begin
               check("imemload_idle", imemload, 32'd0);
            end
            if (!iREN) check("iaddr_idle", iaddr, 32'd0);
         end
      end
   end

   // Issue one fetch at post-edge time and hold it until the scoreboard drains.
   task automatic fetch(input logic [31:0] a, input int waits);
      exp_t e;
      int   s;
      bit   resident;
      s        = set_of(a);
      resident = mv[s] && (mwa[s] == {a[31:2], 2'b00});
      e.addr    = a;
      e.data    = mem_word({a[31:2], 2'b00});
      e.lat     = resident ? 0 : waits + 2;
      e.t_issue = cyc;
      if (!resident) begin
         exp_iaddr = {a[31:2], 2'b00};
         wait_left = waits;
         mv[s]     = 1'b1;
         mwa[s]    = {a[31:2], 2'b00};
         exp_misses++;
      end
      exp_hits++;
      imemREN  = 1'b1;
      imemaddr = a;
      sb.push_back(e);
      n_push++;
      for (int c = 0; c < 64 && n_pop != n_push; c++) @(posedge CLK);
      #1;
      if (n_pop != n_push) begin
         n_vec++; n_err++;
         $display("FAIL fetch_timeout: addr %h never hit, expected %h", a, e.data);
         sb.delete();
         n_pop = n_push;
      end
   endtask

   task automatic idle(input int n);
      imemREN  = 1'b0;
      imemaddr = $urandom;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      model_clear();
      nRST     = 1'b0;
      imemREN  = 1'b0;
      imemaddr = 32'd0;
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      check("rst_ihit", {31'd0, ihit}, 32'd0);
      check("rst_imemload", imemload, 32'd0);
      check("rst_iREN", {31'd0, iREN}, 32'd0);
      check("rst_iaddr", iaddr, 32'd0);

      // Cold miss, re-hit, conflict eviction through set 0.
      fetch(32'h0000_0000, 2);
      fetch(32'h0000_0000, 0);
      fetch(32'h0000_0040, 1);
      fetch(32'h0000_0000, 0);
      idle(1);

      // Miss on 0x8, then change address and drop the request mid-fill.
      mv[set_of(32'h8)]  = 1'b1;
      mwa[set_of(32'h8)] = 32'h0000_0008;
      exp_iaddr = 32'h0000_0008;
      wait_left = 2;
      exp_misses++;
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0008;
      @(posedge CLK);
      #1;
      imemREN  = 1'b0;
      imemaddr = 32'h0000_000C;
      repeat (3) @(posedge CLK);
      #1;
      check("abandon_iREN", {31'd0, iREN}, 32'd0);
      fetch(32'h0000_0008, 0);
      fetch(32'h0000_000C, 1);
      idle(2);

      // Reset in the middle of a fill; the frame table must come back empty.
      exp_iaddr = 32'h0000_0100;
      wait_left = 5;
      imemREN   = 1'b1;
      imemaddr  = 32'h0000_0100;
      repeat (3) @(posedge CLK);
      #1;
      nRST = 1'b0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      check("fetch_rst_iREN", {31'd0, iREN}, 32'd0);
      check("fetch_rst_ihit", {31'd0, ihit}, 32'd0);
      imemREN = 1'b0;
      model_clear();
      wait_left  = 0;
      exp_hits   = 0;
      exp_misses = 0;
      idle(1);
      fetch(32'h0000_0000, 1);

      // Randomized traffic over a small tag range so sets conflict often.
      for (int t = 0; t < 300; t++) begin
         a = (32'($urandom_range(0, 3)) << (2 + IDX_W))
           | (32'($urandom_range(0, SETS - 1)) << 2)
           | 32'($urandom_range(0, 3));
         fetch(a, int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(2);

`ifdef ICACHE_STATS_EN
      check("hit_cnt", hit_cnt, 32'(exp_hits));
      check("miss_cnt", miss_cnt, 32'(exp_misses));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
